vga_timing_engine: RTL

- Parametrised VGA timing and pixel-output engine, successor to the fixed 640x480 RGB332 driver.
- Generates hsync/vsync/data-enable with configurable porches and sync polarity.
- Issues pixel-fetch coordinates ahead of time so a frame buffer with FETCH_LAT cycles of read latency (SRAM or BRAM) sees its data line up with the output timing.
- Supports RGB332, RGB565 and RGB888 input formats; narrow components are expanded to W_OUT bits by bit replication.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_color_expand.sv | 14 +
 rtl/vga_timing_engine.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and format helpers for the VGA timing engine.
package vga_pkg;

  typedef enum logic [1:0] {
    FMT_RGB332,
    FMT_RGB565,
    FMT_RGB888
  } pix_fmt_e;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic ls;
  } vga_timing_t;

  // Component width for a format; idx 0 = red, 1 = green, 2 = blue.
  function automatic int comp_width(pix_fmt_e fmt, int idx);
    case (fmt)
      FMT_RGB332: return (idx == 2) ? 2 : 3;
      FMT_RGB565: return (idx == 1) ? 6 : 5;
      default:    return 8;
    endcase
  endfunction

  function automatic int max_comp_width(pix_fmt_e fmt);
    case (fmt)
      FMT_RGB332: return 3;
      FMT_RGB565: return 6;
      default:    return 8;
    endcase
  endfunction

endpackage

// File: rtl/vga_color_expand.sv
// Widens one colour component to W_OUT bits by MSB-first bit replication.
module vga_color_expand #(
  parameter int W_IN  = 3,
  parameter int W_OUT = 8
) (
  input  logic [W_IN-1:0]  i_comp,
  output logic [W_OUT-1:0] o_comp
);

  for (genvar k = 0; k < W_OUT; k++) begin : g_bit
    assign o_comp[W_OUT-1-k] = i_comp[W_IN-1-(k % W_IN)];
  end

endmodule

// File: rtl/vga_timing_engine.sv
// Parametrised VGA timing generator with latency-matched pixel capture.
// Optional colour-bar generator enabled by VGA_TIMING_ENGINE_TEST_PATTERN_EN.
module vga_timing_engine
  import vga_pkg::*;
#(
  parameter int       H_ACTIVE  = 640,
  parameter int       H_FP      = 16,
  parameter int       H_SYNC    = 96,
  parameter int       H_BP      = 48,
  parameter int       V_ACTIVE  = 480,
  parameter int       V_FP      = 10,
  parameter int       V_SYNC    = 2,
  parameter int       V_BP      = 33,
  parameter int       W_CNT     = 11,
  parameter pix_fmt_e PIX_FMT   = FMT_RGB332,
  parameter int       W_PIX     = 24,
  parameter int       W_OUT     = 8,
  parameter int       FETCH_LAT = 1,
  parameter bit       HS_POL    = 1'b0,
  parameter bit       VS_POL    = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [W_PIX-1:0] i_pix,
  input  logic             i_test_mode,
  output logic [W_CNT-1:0] o_req_x,
  output logic [W_CNT-1:0] o_req_y,
  output logic             o_req_valid,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic [W_OUT-1:0] o_red,
  output logic [W_OUT-1:0] o_green,
  output logic [W_OUT-1:0] o_blue,
  output logic             o_frame_start,
  output logic             o_line_start
);

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int R_W      = comp_width(PIX_FMT, 0);
  localparam int G_W      = comp_width(PIX_FMT, 1);
  localparam int B_W      = comp_width(PIX_FMT, 2);
  localparam int B_LSB    = 0;
  localparam int G_LSB    = B_W;
  localparam int R_LSB    = B_W + G_W;

  if (H_TOT > (1 << W_CNT)) begin : g_bad_htot
    $error("vga_timing_engine: horizontal total does not fit in W_CNT bits");
  end
  if (V_TOT > (1 << W_CNT)) begin : g_bad_vtot
    $error("vga_timing_engine: vertical total does not fit in W_CNT bits");
  end
  if (FETCH_LAT < 0 || FETCH_LAT > 4) begin : g_bad_lat
    $error("vga_timing_engine: FETCH_LAT must be within 0..4");
  end
  if (W_OUT < max_comp_width(PIX_FMT) || W_PIX < R_W + G_W + B_W) begin : g_bad_width
    $error("vga_timing_engine: W_OUT or W_PIX too narrow for PIX_FMT");
  end

`ifdef VGA_TIMING_ENGINE_TEST_PATTERN_EN
  typedef struct packed {
    vga_timing_t tim;
    logic [2:0]  bar;
  } stg_t;
  localparam stg_t STG_IDLE = '{tim: '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0, fs: 1'b0, ls: 1'b0},
                                bar: 3'd0};
`else
  typedef struct packed {
    vga_timing_t tim;
  } stg_t;
  localparam stg_t STG_IDLE = '{tim: '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0, fs: 1'b0, ls: 1'b0}};
`endif

  logic [W_CNT-1:0] hcnt, vcnt;
  logic [31:0]      h_i, v_i;
  logic             h_last, v_last;
  stg_t             stg_in, stg_dly;

  assign h_i    = 32'(hcnt);
  assign v_i    = 32'(vcnt);
  assign h_last = (h_i == H_TOT - 1);
  assign v_last = (v_i == V_TOT - 1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign o_req_x     = hcnt;
  assign o_req_y     = vcnt;
  assign o_req_valid = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);

  always_comb begin
    stg_in        = STG_IDLE;
    stg_in.tim.hs = ((h_i >= HS_START) && (h_i < HS_END)) ? HS_POL : ~HS_POL;
    stg_in.tim.vs = ((v_i >= VS_START) && (v_i < VS_END)) ? VS_POL : ~VS_POL;
    stg_in.tim.de = o_req_valid;
    stg_in.tim.fs = o_req_valid && (hcnt == '0) && (vcnt == '0);
    stg_in.tim.ls = o_req_valid && (hcnt == '0);
`ifdef VGA_TIMING_ENGINE_TEST_PATTERN_EN
    stg_in.bar    = 3'((h_i * 8) / H_ACTIVE);
`endif
  end

  // Delay the decoded timing so it meets the frame buffer's read data.
  if (FETCH_LAT == 0) begin : g_nodly
    assign stg_dly = stg_in;
  end else begin : g_dly
    stg_t sr [FETCH_LAT];
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        for (int i = 0; i < FETCH_LAT; i++) sr[i] <= STG_IDLE;
      end else begin
        sr[0] <= stg_in;
        for (int i = 1; i < FETCH_LAT; i++) sr[i] <= sr[i-1];
      end
    end
    assign stg_dly = sr[FETCH_LAT-1];
  end

  logic [R_W-1:0]   r_raw;
  logic [G_W-1:0]   g_raw;
  logic [B_W-1:0]   b_raw;
  logic [W_OUT-1:0] r_exp, g_exp, b_exp;
  logic [W_OUT-1:0] red_nxt, green_nxt, blue_nxt;

  assign r_raw = i_pix[R_LSB +: R_W];
  assign g_raw = i_pix[G_LSB +: G_W];
  assign b_raw = i_pix[B_LSB +: B_W];

  vga_color_expand #(.W_IN(R_W), .W_OUT(W_OUT)) u_exp_r (.i_comp(r_raw), .o_comp(r_exp));
  vga_color_expand #(.W_IN(G_W), .W_OUT(W_OUT)) u_exp_g (.i_comp(g_raw), .o_comp(g_exp));
  vga_color_expand #(.W_IN(B_W), .W_OUT(W_OUT)) u_exp_b (.i_comp(b_raw), .o_comp(b_exp));

  always_comb begin
    red_nxt   = '0;
    green_nxt = '0;
    blue_nxt  = '0;
    if (stg_dly.tim.de) begin
      red_nxt   = r_exp;
      green_nxt = g_exp;
      blue_nxt  = b_exp;
`ifdef VGA_TIMING_ENGINE_TEST_PATTERN_EN
      // Bars run white, yellow, cyan, green, magenta, red, blue, black.
      if (i_test_mode) begin
        red_nxt   = {W_OUT{~stg_dly.bar[1]}};
        green_nxt = {W_OUT{~stg_dly.bar[2]}};
        blue_nxt  = {W_OUT{~stg_dly.bar[0]}};
      end
`endif
    end
  end

`ifndef VGA_TIMING_ENGINE_TEST_PATTERN_EN
  logic unused_test_mode;
  assign unused_test_mode = i_test_mode;
`endif
  logic unused_pix;
  assign unused_pix = ^i_pix;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_hsync       <= ~HS_POL;
      o_vsync       <= ~VS_POL;
      o_de          <= 1'b0;
      o_frame_start <= 1'b0;
      o_line_start  <= 1'b0;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
    end else begin
      o_hsync       <= stg_dly.tim.hs;
      o_vsync       <= stg_dly.tim.vs;
      o_de          <= stg_dly.tim.de;
      o_frame_start <= stg_dly.tim.fs;
      o_line_start  <= stg_dly.tim.ls;
      o_red         <= red_nxt;
      o_green       <= green_nxt;
      o_blue        <= blue_nxt;
    end
  end

endmodule
